taylor_series_engine: RTL

//  Self-contained, parametrised Taylor-series evaluator for e^x, cosh(x) and sinh(x) on an unsigned fractional input.

---
 rtl/taylor_series_engine_if.sv | 16 +
 rtl/taylor_series_engine.sv | 98 +++++++++
 2 files changed

// File: rtl/taylor_series_engine_if.sv
// Start/done handshake bundle for the Taylor-series function unit.
// The sequencer drives the request side (master); the engine answers on the slave side.
interface taylor_series_engine_if #(
    parameter int W     = 16,
    parameter int IBITS = 2
);
    logic               start;
    logic [1:0]         mode;
    logic [W-1:0]       x;
    logic               busy;
    logic               done;
    logic [W+IBITS-1:0] result;

    modport master (output start, mode, x, input busy, done, result);
    modport slave  (input start, mode, x, output busy, done, result);
endinterface

// File: rtl/taylor_series_engine.sv
// Iterative Taylor-series evaluator for e^x, cosh(x), sinh(x) with x in [0,1) as Q0.W.
// Each term costs two cycles: multiply by x, then by 1/n from a constant ROM.
module taylor_series_engine #(
    parameter int W     = 16,
    parameter int IBITS = 2,
    parameter int TERMS = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    taylor_series_engine_if.slave  bus
);
    localparam int RW = W + IBITS;
    localparam logic [W:0] ONE = {1'b1, {W{1'b0}}};

    typedef enum logic [1:0] {IDLE, MULX, MULC, DONE} state_t;
    typedef enum logic [1:0] {M_EXP, M_COSH, M_SINH, M_RSVD} mode_t;

    state_t        state, state_nx;
    mode_t         mode_r;
    logic [W-1:0]  xr;
    logic [W-1:0]  term;
    logic [3:0]    n;
    logic [RW-1:0] result;

    logic [W-1:0]  coef_rom [16];
    logic [W-1:0]  term_x, term_c;
    logic [RW:0]   sum;
    logic [RW-1:0] sum_sat;
    logic          accept, sel;

    // 1/n in Q0.W; 1/1 is clipped to the largest representable fraction.
    for (genvar i = 0; i < 16; i++) begin : g_coef
        if (i == 0) begin : g_zero
            assign coef_rom[i] = '0;
        end else if (i == 1) begin : g_one
            assign coef_rom[i] = '1;
        end else begin : g_div
            assign coef_rom[i] = W'(ONE / (W+1)'(i));
        end
    end

    assign accept  = bus.start && (state == IDLE || state == DONE);
    assign term_x  = W'(({{W{1'b0}}, term} * {{W{1'b0}}, xr}) >> W);
    assign term_c  = W'(({{W{1'b0}}, term} * {{W{1'b0}}, coef_rom[n]}) >> W);
    assign sum     = {1'b0, result} + (RW+1)'(term_c);
    assign sum_sat = sum[RW] ? '1 : sum[RW-1:0];

    always_comb begin
        // NOTE: every signal gets a default before the case so no latch can be inferred.
        sel      = 1'b1;
        state_nx = state;
        case (mode_r)
            M_COSH:  sel = ~n[0];
            M_SINH:  sel = n[0];
            default: sel = 1'b1;
        endcase
        case (state)
            IDLE:    if (accept) state_nx = MULX;
            MULX:    state_nx = MULC;
            MULC:    state_nx = (n == 4'(TERMS)) ? DONE : MULX;
            DONE:    state_nx = accept ? MULX : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    // NOTE: every datapath register is reset so a dropped run leaves no stale term or sum.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            xr     <= '0;
            mode_r <= M_EXP;
            term   <= '0;
            n      <= '0;
            result <= '0;
        end else if (accept) begin
            xr     <= bus.x;
            mode_r <= mode_t'(bus.mode);
            term   <= '1;
            n      <= 4'd1;
            result <= (bus.mode == 2'd2) ? '0 : RW'(ONE);
        end else if (state == MULX) begin
            term <= term_x;
        end else if (state == MULC) begin
            term <= term_c;
            n    <= n + 4'd1;
            if (sel) result <= sum_sat;
        end
    end

    assign bus.busy   = (state == MULX) || (state == MULC);
    assign bus.done   = (state == DONE);
    assign bus.result = result;
endmodule
